lsu_unit: RTL

Parametrised load/store unit for the RV32I core, generalisable to 64-bit data paths. Sits between the EXECUTE/MEMORY stages and the data memory port. Takes one load/store request per transaction, word-aligns the address, and generates byte strobes. Load data is sign- or zero-extended; misaligned accesses and unresponsive memory are reported as errors instead of hanging the core.

---
 rtl/lsu_unit_pkg.sv | 22 ++
 rtl/lsu_unit_if.sv | 36 +++
 rtl/lsu_unit_align.sv | 41 ++++
 rtl/lsu_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/lsu_unit_pkg.sv
// lsu_unit_pkg: shared types and fun3 encodings for the load/store unit
package lsu_unit_pkg;
  typedef enum logic [1:0] {
    MEM_SIZE_B = 2'b00,
    MEM_SIZE_H = 2'b01,
    MEM_SIZE_W = 2'b10,
    MEM_SIZE_D = 2'b11
  } mem_size_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_TIMEOUT, ERR_ILLEGAL} lsu_err_t;
  localparam logic [2:0] LOAD_FUN3_LB  = 3'b000;
  localparam logic [2:0] LOAD_FUN3_LH  = 3'b001;
  localparam logic [2:0] LOAD_FUN3_LW  = 3'b010;
  localparam logic [2:0] LOAD_FUN3_LD  = 3'b011;
  localparam logic [2:0] LOAD_FUN3_LBU = 3'b100;
  localparam logic [2:0] LOAD_FUN3_LHU = 3'b101;
  localparam logic [2:0] LOAD_FUN3_LWU = 3'b110;
  localparam logic [2:0] STORE_FUN3_SB = 3'b000;
  localparam logic [2:0] STORE_FUN3_SH = 3'b001;
  localparam logic [2:0] STORE_FUN3_SW = 3'b010;
  localparam logic [2:0] STORE_FUN3_SD = 3'b011;
endpackage

// File: rtl/lsu_unit_if.sv
// lsu_unit_if: request/response and memory-port bundle; master = core+memory side, slave = lsu_unit
interface lsu_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [2:0]              req_fun3;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic [1:0]              resp_err;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_wstrb;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  modport master (
    output req_valid, req_we, req_fun3, req_addr, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport slave (
    input  req_valid, req_we, req_fun3, req_addr, req_wdata, resp_ready,
           mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/lsu_unit_align.sv
// lsu_align: combinational fun3 decode, legality/alignment check, store lane/strobe build, load lane extract+extend
module lsu_align
  import lsu_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                              we,
  input  logic [2:0]                        fun3,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]   off,
  input  logic [DATA_WIDTH-1:0]             wdata,
  input  logic [DATA_WIDTH-1:0]             rdata,
  output lsu_err_t                          err,
  output logic [DATA_WIDTH/8-1:0]           wstrb,
  output logic [DATA_WIDTH-1:0]             wlane,
  output logic [DATA_WIDTH-1:0]             rext
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam bit WIDE = DATA_WIDTH == 64;
  mem_size_t size;
  logic [OFF_W-1:0] lo_mask;
  logic illegal, misalign, sgn;
  logic [DATA_WIDTH-1:0] lane;
  assign size = mem_size_t'(fun3[1:0]);
  assign illegal = we ? (fun3[2] || (size == MEM_SIZE_D && !WIDE))
                      : (fun3 == 3'b111 || ((fun3 == LOAD_FUN3_LD || fun3 == LOAD_FUN3_LWU) && !WIDE));
  assign lo_mask = OFF_W'({fun3[1:0] == 2'b11, fun3[1], |fun3[1:0]});
  assign misalign = |(off & lo_mask);
  assign err = illegal ? ERR_ILLEGAL : misalign ? ERR_MISALIGN : ERR_NONE;
  assign wstrb = we ? (NB'(size == MEM_SIZE_B ? 8'h01 : size == MEM_SIZE_H ? 8'h03 :
                           size == MEM_SIZE_W ? 8'h0F : 8'hFF) << off) : '0;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign wlane[8*i +: 8] = wdata[{OFF_W'(i) & lo_mask, 3'b000} +: 8];
  end
  assign lane = rdata >> {off, 3'b000};
  assign sgn = !fun3[2];
  assign rext = size == MEM_SIZE_B ? (sgn ? DATA_WIDTH'($signed(lane[7:0]))  : DATA_WIDTH'(lane[7:0]))
              : size == MEM_SIZE_H ? (sgn ? DATA_WIDTH'($signed(lane[15:0])) : DATA_WIDTH'(lane[15:0]))
              : size == MEM_SIZE_W ? (sgn ? DATA_WIDTH'($signed(lane[31:0])) : DATA_WIDTH'(lane[31:0]))
              : lane;
endmodule

// File: rtl/lsu_unit.sv
// lsu_unit: load/store FSM (clk, rst, bus: req_*/resp_* core side, mem_* registered memory port)
module lsu_unit
  import lsu_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic       clk,
  input logic       rst,
  lsu_unit_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  lsu_state_t state, nxt;
  logic we_q;
  logic [2:0] fun3_q;
  logic [OFF_W-1:0] off_q;
  logic [15:0] cnt;
  logic mrv, mwe;
  logic [ADDR_WIDTH-1:0] maddr;
  logic [DATA_WIDTH-1:0] mwdata, rdata_q;
  logic [NB-1:0] mstrb;
  lsu_err_t err_q;
  logic idle, ok, timeout, a_we;
  logic [2:0] a_fun3;
  logic [OFF_W-1:0] a_off;
  lsu_err_t chk_err;
  logic [NB-1:0] strb;
  logic [DATA_WIDTH-1:0] wlane, rext;
  assign idle = state == IDLE;
  assign a_we = idle ? bus.req_we : we_q;
  assign a_fun3 = idle ? bus.req_fun3 : fun3_q;
  assign a_off = idle ? bus.req_addr[OFF_W-1:0] : off_q;
  assign ok = chk_err == ERR_NONE;
  assign timeout = cnt == 16'(TIMEOUT_CYCLES - 1);
  lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .we    (a_we),
    .fun3  (a_fun3),
    .off   (a_off),
    .wdata (bus.req_wdata),
    .rdata (bus.mem_rdata),
    .err   (chk_err),
    .wstrb (strb),
    .wlane (wlane),
    .rext  (rext)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      fun3_q  <= '0;
      off_q   <= '0;
      cnt     <= '0;
      mrv     <= 1'b0;
      mwe     <= 1'b0;
      maddr   <= '0;
      mwdata  <= '0;
      mstrb   <= '0;
      rdata_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state <= nxt;
      if (idle && bus.req_valid) begin
        we_q    <= bus.req_we;
        fun3_q  <= bus.req_fun3;
        off_q   <= bus.req_addr[OFF_W-1:0];
        mrv     <= ok;
        mwe     <= ok && bus.req_we;
        maddr   <= ok ? {bus.req_addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)} : '0;
        mwdata  <= ok ? wlane : '0;
        mstrb   <= ok ? strb : '0;
        err_q   <= chk_err;
        rdata_q <= '0;
      end
      if (state == ISSUE && bus.mem_req_ready) begin
        mrv    <= 1'b0;
        mwe    <= 1'b0;
        maddr  <= '0;
        mwdata <= '0;
        mstrb  <= '0;
        cnt    <= '0;
      end
      if (state == WAIT) begin
        cnt <= cnt + 16'd1;
        if (bus.mem_resp_valid || timeout) begin
          err_q   <= bus.mem_resp_valid ? ERR_NONE : ERR_TIMEOUT;
          rdata_q <= (bus.mem_resp_valid && !we_q) ? rext : '0;
        end
      end
      if (state == DONE && bus.resp_ready) begin
        err_q   <= ERR_NONE;
        rdata_q <= '0;
      end
    end
  end
  always_comb begin
    nxt = state == IDLE  ? (bus.req_valid ? (ok ? ISSUE : DONE) : IDLE)
        : state == ISSUE ? (bus.mem_req_ready ? WAIT : ISSUE)
        : state == WAIT  ? ((bus.mem_resp_valid || timeout) ? DONE : WAIT)
        : (bus.resp_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.req_ready     = state == IDLE;
    bus.resp_valid    = state == DONE;
    bus.resp_rdata    = rdata_q;
    bus.resp_err      = err_q;
    bus.mem_req_valid = mrv;
    bus.mem_we        = mwe;
    bus.mem_addr      = maddr;
    bus.mem_wdata     = mwdata;
    bus.mem_wstrb     = mstrb;
  end
endmodule
